// File: rtl/fano_sync_monitor.sv
// Per-channel sync monitor: counts decoder error events per window of decoded bits,
// drives the lock flag and requests resyncs. Optional statistics behind `FANO_SYNC_STAT_EN.
module fano_sync_monitor #(
  parameter int CNT_W          = 24,
  parameter int LOCK_WINDOWS   = 2,
  parameter int UNLOCK_WINDOWS = 3
) (
  input  logic             s_axi_aclk,
  input  logic             reset,
  input  logic             i_ctrl_reset,
  input  logic [CNT_W-1:0] i_sync_period,
  input  logic [CNT_W-1:0] i_sync_threshold,
  input  logic             i_bit_valid,
  input  logic             i_err,
  output logic             o_sync,
  output logic             o_resync,
  output logic             o_window_done,
  output logic [CNT_W-1:0] o_err_count
`ifdef FANO_SYNC_STAT_EN
  ,
  output logic [31:0]      o_lock_loss_cnt,
  output logic [31:0]      o_window_cnt
`endif
);

  localparam int LOCK_W   = (LOCK_WINDOWS   < 2) ? 1 : $clog2(LOCK_WINDOWS + 1);
  localparam int UNLOCK_W = (UNLOCK_WINDOWS < 2) ? 1 : $clog2(UNLOCK_WINDOWS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [LOCK_W-1:0]  good_run_q, good_run_d;
  logic [UNLOCK_W-1:0] bad_run_q, bad_run_d;
  logic               done_q, done_d;
  logic               resync_q, resync_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [31:0]        lock_loss_q, lock_loss_d;
  logic [31:0]        window_cnt_q, window_cnt_d;

  logic               clear;
  logic [CNT_W-1:0]   err_final;
  logic               win_close;
  logic               win_good;

  assign clear = reset | i_ctrl_reset;

  // Error count including the current bit, so an error on the closing bit lands in its window.
  assign err_final = (i_bit_valid && i_err && (err_cnt_q != {CNT_W{1'b1}}))
                   ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  assign win_close = (state_q != ST_IDLE) && (period_q != '0) && i_bit_valid
                   && (bit_cnt_q == period_q - CNT_W'(1));
  // Threshold 0 can never be beaten, so such windows are always bad.
  assign win_good  = (err_final < thr_q);

  // NOTE: every next-state signal gets its hold value first, so no path through the
  // case below leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    thr_d        = thr_q;
    bit_cnt_d    = bit_cnt_q;
    err_cnt_d    = err_cnt_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    done_d       = 1'b0;
    resync_d     = 1'b0;
    err_count_d  = err_count_q;
    lock_loss_d  = lock_loss_q;
    window_cnt_d = window_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Track the programmed values; the first window uses what is latched on exit.
        period_d  = i_sync_period;
        thr_d     = i_sync_threshold;
        bit_cnt_d = '0;
        err_cnt_d = '0;
        if (period_q != '0) begin
          state_d    = ST_SEARCH;
          good_run_d = '0;
          bad_run_d  = '0;
        end
      end

      ST_SEARCH, ST_LOCKED: begin
        if (period_q == '0) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          err_cnt_d  = '0;
          good_run_d = '0;
          bad_run_d  = '0;
        end else if (win_close) begin
          done_d       = 1'b1;
          err_count_d  = err_final;
          bit_cnt_d    = '0;
          err_cnt_d    = '0;
          period_d     = i_sync_period;
          thr_d        = i_sync_threshold;
          window_cnt_d = window_cnt_q + 32'd1;

          if (state_q == ST_SEARCH) begin
            if (win_good) begin
              bad_run_d = '0;
              if (good_run_q >= LOCK_W'(LOCK_WINDOWS - 1)) begin
                state_d    = ST_LOCKED;
                good_run_d = '0;
              end else begin
                good_run_d = good_run_q + LOCK_W'(1);
              end
            end else begin
              good_run_d = '0;
              resync_d   = 1'b1;
            end
          end else begin
            if (win_good) begin
              bad_run_d = '0;
            end else if (bad_run_q >= UNLOCK_W'(UNLOCK_WINDOWS - 1)) begin
              state_d    = ST_SEARCH;
              bad_run_d  = '0;
              good_run_d = '0;
              resync_d   = 1'b1;
              if (lock_loss_q != 32'hFFFF_FFFF) lock_loss_d = lock_loss_q + 32'd1;
            end else begin
              bad_run_d = bad_run_q + UNLOCK_W'(1);
            end
          end
        end else if (i_bit_valid) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          err_cnt_d = err_final;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values computed in the previous cycle regardless of statement order.
  always_ff @(posedge s_axi_aclk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      period_q     <= '0;
      thr_q        <= '0;
      bit_cnt_q    <= '0;
      err_cnt_q    <= '0;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      done_q       <= 1'b0;
      resync_q     <= 1'b0;
      err_count_q  <= '0;
      lock_loss_q  <= '0;
      window_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      thr_q        <= thr_d;
      bit_cnt_q    <= bit_cnt_d;
      err_cnt_q    <= err_cnt_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      done_q       <= done_d;
      resync_q     <= resync_d;
      err_count_q  <= err_count_d;
      lock_loss_q  <= lock_loss_d;
      window_cnt_q <= window_cnt_d;
    end
  end

  assign o_sync        = (state_q == ST_LOCKED);
  assign o_resync      = resync_q;
  assign o_window_done = done_q;
  assign o_err_count   = err_count_q;

`ifdef FANO_SYNC_STAT_EN
  assign o_lock_loss_cnt = lock_loss_q;
  assign o_window_cnt    = window_cnt_q;
`else
  // Statistics are compiled out; the counters have no reader and are trimmed.
  logic unused_stat;
  assign unused_stat = ^{lock_loss_q, window_cnt_q};
`endif

endmodule

// File: tb/tb_fano_sync_monitor.sv
// Self-checking bench for fano_sync_monitor: directed scenarios plus random soak,
// compared every cycle against a window-result reference model.
module tb_fano_sync_monitor;
  localparam int CNT_W  = 24;
  localparam int LOCK   = 2;
  localparam int UNLOCK = 3;
  localparam longint ERR_MAX = (64'd1 << CNT_W) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;

  logic             s_axi_aclk = 1'b0;
  logic             reset;
  logic             i_ctrl_reset;
  logic [CNT_W-1:0] i_sync_period;
  logic [CNT_W-1:0] i_sync_threshold;
  logic             i_bit_valid;
  logic             i_err;
  logic             o_sync;
  logic             o_resync;
  logic             o_window_done;
  logic [CNT_W-1:0] o_err_count;
`ifdef FANO_SYNC_STAT_EN
  logic [31:0]      o_lock_loss_cnt;
  logic [31:0]      o_window_cnt;
`endif

  fano_sync_monitor #(
    .CNT_W(CNT_W), .LOCK_WINDOWS(LOCK), .UNLOCK_WINDOWS(UNLOCK)
  ) dut (
    .s_axi_aclk      (s_axi_aclk),
    .reset           (reset),
    .i_ctrl_reset    (i_ctrl_reset),
    .i_sync_period   (i_sync_period),
    .i_sync_threshold(i_sync_threshold),
    .i_bit_valid     (i_bit_valid),
    .i_err           (i_err),
    .o_sync          (o_sync),
    .o_resync        (o_resync),
    .o_window_done   (o_window_done),
    .o_err_count     (o_err_count)
`ifdef FANO_SYNC_STAT_EN
    ,
    .o_lock_loss_cnt (o_lock_loss_cnt),
    .o_window_cnt    (o_window_cnt)
`endif
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks window results since the last mode change and decides
  // lock/unlock from the tail of that history.
  int     m_mode;
  longint m_per, m_thr, m_bits, m_errs;
  bit     m_hist[$];
  bit     e_done, e_resync;
  longint e_cnt;
  longint m_lock_loss, m_windows;

  function automatic bit tail_all(int n, bit val);
    if (m_hist.size() < n) return 1'b0;
    for (int i = m_hist.size() - n; i < m_hist.size(); i++)
      if (m_hist[i] != val) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit e,
                            input longint per_in, input longint thr_in);
    longint errs_now;
    bit good;
    if (rst) begin
      m_mode = M_IDLE; m_per = 0; m_thr = 0; m_bits = 0; m_errs = 0;
      m_hist.delete(); e_done = 0; e_resync = 0; e_cnt = 0;
      m_lock_loss = 0; m_windows = 0;
      return;
    end
    e_done = 0;
    e_resync = 0;
    if (m_mode == M_IDLE) begin
      if (m_per != 0) begin
        m_mode = M_SEARCH;
        m_hist.delete();
      end
      m_per = per_in; m_thr = thr_in; m_bits = 0; m_errs = 0;
    end else if (m_per == 0) begin
      m_mode = M_IDLE; m_hist.delete(); m_bits = 0; m_errs = 0;
    end else if (v) begin
      errs_now = m_errs + e;
      if (errs_now > ERR_MAX) errs_now = ERR_MAX;
      if (m_bits + 1 == m_per) begin
        e_done = 1; e_cnt = errs_now; good = (errs_now < m_thr);
        m_windows = (m_windows + 1) % (64'd1 << 32);
        m_bits = 0; m_errs = 0; m_per = per_in; m_thr = thr_in;
        m_hist.push_back(good);
        if (m_mode == M_SEARCH) begin
          if (!good) e_resync = 1;
          else if (tail_all(LOCK, 1'b1)) begin
            m_mode = M_LOCKED; m_hist.delete();
          end
        end else if (!good && tail_all(UNLOCK, 1'b0)) begin
          m_mode = M_SEARCH; m_hist.delete(); e_resync = 1;
          if (m_lock_loss < 64'hFFFF_FFFF) m_lock_loss++;
        end
      end else begin
        m_bits++; m_errs = errs_now;
      end
    end
  endtask

  int done_cnt, resync_cnt, valid_cnt;

  // One clock: inputs driven at the negedge, model advanced at the posedge,
  // outputs compared at the following negedge.
  task automatic step(input bit v, input bit e, input bit ctrl = 1'b0);
    i_bit_valid  = v;
    i_err        = e;
    i_ctrl_reset = ctrl;
    @(posedge s_axi_aclk);
    model_step(reset | ctrl, v, e, longint'(i_sync_period), longint'(i_sync_threshold));
    @(negedge s_axi_aclk);
    check("sync",        o_sync,        m_mode == M_LOCKED);
    check("window_done", o_window_done, e_done);
    check("resync",      o_resync,      e_resync);
    check("err_count",   o_err_count,   e_cnt);
`ifdef FANO_SYNC_STAT_EN
    check("lock_loss_cnt", o_lock_loss_cnt, m_lock_loss);
    check("window_cnt",    o_window_cnt,    m_windows);
`endif
    if (v) valid_cnt++;
    if (o_window_done) done_cnt++;
    if (o_resync) resync_cnt++;
  endtask

  task automatic send_window(input int len, input int n_err);
    int off;
    off = int'($urandom_range(0, len - 1));
    for (int i = 0; i < len; i++) step(1'b1, ((i + off) % len) < n_err);
  endtask

  initial begin
    reset = 1'b1; i_ctrl_reset = 1'b0; i_bit_valid = 1'b0; i_err = 1'b0;
    i_sync_period = '0; i_sync_threshold = '0;
    repeat (3) step(1'b0, 1'b0);
    check("reset_sync", o_sync, 0);
    check("reset_done", o_window_done, 0);
    reset = 1'b0;

    // Period 0: bits stream but nothing happens.
    done_cnt = 0;
    repeat (20) step(1'b1, 1'($urandom_range(0, 1)));
    check("p0_no_done", done_cnt, 0);
    check("p0_sync", o_sync, 0);

    // First window closes one cycle after the 8th bit; lock after window 2.
    i_sync_period = 8; i_sync_threshold = 2;
    repeat (3) step(1'b0, 1'b0);
    done_cnt = 0; resync_cnt = 0;
    repeat (7) step(1'b1, 1'b0);
    check("no_done_before_8", done_cnt, 0);
    step(1'b1, 1'b0);
    check("first_done_after_8", o_window_done, 1);
    check("win1_not_locked", o_sync, 0);
    send_window(8, 0);
    check("win2_locked", o_sync, 1);
    check("lock_no_resync", resync_cnt, 0);

    // Three bad windows while locked.
    resync_cnt = 0;
    for (int w = 0; w < 3; w++) begin
      send_window(8, 3);
      if (w < 2) check("still_locked", o_sync, 1);
    end
    check("unlock_sync", o_sync, 0);
    check("unlock_resync", o_resync, 1);
    check("unlock_err_count", o_err_count, 3);
    check("unlock_one_resync", resync_cnt, 1);
`ifdef FANO_SYNC_STAT_EN
    check("unlock_lock_loss", o_lock_loss_cnt, 1);
`endif

    // SEARCH with bad windows, and an interrupted good run.
    resync_cnt = 0;
    repeat (3) send_window(8, 5);
    check("search_resync_each", resync_cnt, 3);
    send_window(8, 0);
    send_window(8, 5);
    send_window(8, 0);
    check("broken_run_unlocked", o_sync, 0);
    send_window(8, 1);
    check("two_good_locked", o_sync, 1);

    // Error on the closing bit only, then a mid-window period change.
    i_sync_period = 4; i_sync_threshold = 1;
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    resync_cnt = 0;
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("close_err_done", o_window_done, 1);
    check("close_err_count", o_err_count, 1);
    check("close_err_bad", o_resync, 1);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    i_sync_period = 6;
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("old_period_close", o_window_done, 1);
    done_cnt = 0;
    repeat (5) step(1'b1, 1'b0);
    check("new_period_open", done_cnt, 0);
    step(1'b1, 1'b0);
    check("new_period_close", o_window_done, 1);

    // Lock, then control reset mid-window.
    i_sync_period = 4; i_sync_threshold = 4;
    repeat (2) send_window(4, 0);
    check("relock", o_sync, 1);
    step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("ctrl_sync", o_sync, 0);
    check("ctrl_err_count", o_err_count, 0);
`ifdef FANO_SYNC_STAT_EN
    check("ctrl_lock_loss", o_lock_loss_cnt, 0);
    check("ctrl_window_cnt", o_window_cnt, 0);
`endif
    step(1'b0, 1'b0);
    check("ctrl_after_sync", o_sync, 0);

    // Period 1: every valid bit closes a window.
    i_sync_period = 1; i_sync_threshold = 1;
    repeat (3) step(1'b0, 1'b0);
    done_cnt = 0; valid_cnt = 0;
    repeat (40) step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
    step(1'b0, 1'b0);
    check("period1_every_bit", done_cnt, valid_cnt);

    // Random soak with changing configuration.
    for (int c = 0; c < 600; c++) begin
      if ((c % 40) == 0) begin
        i_sync_period    = ($urandom_range(0, 15) == 0) ? '0 : CNT_W'($urandom_range(1, 10));
        i_sync_threshold = CNT_W'($urandom_range(0, 4));
      end
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 249) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
